// File: rtl/uart_pkg.sv
// Shared UART package: default channel constants and the helper functions that
// derive counter widths from them. Imported by the baud generator interface,
// the fractional prescaler and the baud generator top.
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_DIV_W      = 16;
  localparam int UART_FRAC_W     = 4;
  localparam int UART_OS_RATE    = 16;
  localparam int UART_FRAME_BITS = 10;

  // Width of the oversample counter (0 .. os_rate-1).
  function automatic int os_cnt_width(input int os_rate);
    return (os_rate > 2) ? $clog2(os_rate) : 1;
  endfunction

  // Width of the frame bit counter (0 .. frame_bits).
  function automatic int bit_cnt_width(input int frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

  localparam int OS_CNT_W  = os_cnt_width(UART_OS_RATE);
  localparam int BIT_CNT_W = bit_cnt_width(UART_FRAME_BITS);

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control/status bundle of one baud generator instance.
//   master: the channel FSM; drives enable, restart and the divisor, and
//           receives the tick pulses and counters.
//   slave : the baud generator itself.
`timescale 1ns/1ps
interface uart_baud_gen_if
  import uart_pkg::*;
#(
  parameter int DIV_W      = UART_DIV_W,
  parameter int FRAC_W     = UART_FRAC_W,
  parameter int OS_RATE    = UART_OS_RATE,
  parameter int FRAME_BITS = UART_FRAME_BITS
);

  localparam int OS_W = os_cnt_width(OS_RATE);
  localparam int BC_W = bit_cnt_width(FRAME_BITS);

  logic              enable;
  logic              restart;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic              frame_done;
  logic [OS_W-1:0]   os_cnt;
  logic [BC_W-1:0]   bit_cnt;

  modport master (
    output enable, restart, div_int, div_frac,
    input  os_tick, mid_tick, bit_tick, frame_done, os_cnt, bit_cnt
  );

  modport slave (
    input  enable, restart, div_int, div_frac,
    output os_tick, mid_tick, bit_tick, frame_done, os_cnt, bit_cnt
  );

endinterface

// File: rtl/uart_frac_prescaler.sv
// Fractional prescaler: divides clk by div_q + frac_q/2^FRAC_W on average and
// emits a combinational one-cycle raw tick per oversample period.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   enable         advance the period counter; hold everything when low
//   restart        clear pc/acc/carry and capture the divisor (beats enable)
//   reload         capture the divisor at a bit boundary (only used with a tick)
//   div_int        integer cycles per tick (0 behaves as 1)
//   div_frac       fractional cycles per tick, units of 2^-FRAC_W
//   tick           raw oversample tick, valid in the cycle pc hits its terminal
`timescale 1ns/1ps
module uart_frac_prescaler
  import uart_pkg::*;
#(
  parameter int DIV_W  = UART_DIV_W,
  parameter int FRAC_W = UART_FRAC_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              restart,
  input  logic              reload,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick
);

  logic [DIV_W-1:0]  div_q_reg;
  logic [FRAC_W-1:0] frac_q_reg;
  logic [DIV_W-1:0]  pc_reg;
  logic [FRAC_W-1:0] acc_reg;
  logic              carry_reg;

  // One extra bit so that div_q + carry cannot overflow.
  logic [DIV_W:0]    period_len;
  logic [DIV_W:0]    period_last;
  logic [FRAC_W:0]   acc_sum;
  logic              terminal;

  always_comb begin
    period_len = (div_q_reg == '0) ? {{DIV_W{1'b0}}, 1'b1} : {1'b0, div_q_reg};
    period_len = period_len + {{DIV_W{1'b0}}, carry_reg};
    period_last = period_len - 1'b1;
    acc_sum = {1'b0, acc_reg} + {1'b0, frac_q_reg};
    terminal = ({1'b0, pc_reg} == period_last);
  end

  // A restart landing on a terminal count suppresses the tick.
  assign tick = enable && !restart && terminal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q_reg  <= '0;
      frac_q_reg <= '0;
      pc_reg     <= '0;
      acc_reg    <= '0;
      carry_reg  <= 1'b0;
    end else if (restart) begin
      div_q_reg  <= div_int;
      frac_q_reg <= div_frac;
      pc_reg     <= '0;
      acc_reg    <= '0;
      carry_reg  <= 1'b0;
    end else if (enable) begin
      if (terminal) begin
        pc_reg    <= '0;
        // Carry out of the accumulator stretches the following period.
        acc_reg   <= acc_sum[FRAC_W-1:0];
        carry_reg <= acc_sum[FRAC_W];
        if (reload) begin
          div_q_reg  <= div_int;
          frac_q_reg <= div_frac;
        end
      end else begin
        pc_reg <= pc_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud tick generator and bit/frame sequencer for one UART channel.
// A fractional prescaler produces oversample ticks; this level counts them
// into bits and bits into frames, and registers all pulse outputs.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   bus (slave)    enable, restart, div_int, div_frac in;
//                  os_tick, mid_tick, bit_tick, frame_done, os_cnt, bit_cnt out
`timescale 1ns/1ps
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W      = UART_DIV_W,
  parameter int FRAC_W     = UART_FRAC_W,
  parameter int OS_RATE    = UART_OS_RATE,
  parameter int FRAME_BITS = UART_FRAME_BITS
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_baud_gen_if.slave bus
);

  localparam int OS_W = os_cnt_width(OS_RATE);
  localparam int BC_W = bit_cnt_width(FRAME_BITS);

  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OS_RATE - 1);
  localparam logic [OS_W-1:0] OS_PREMID = OS_W'(OS_RATE / 2 - 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(FRAME_BITS - 1);

  logic            raw_tick;
  logic            os_wrap;
  logic            frame_wrap;
  logic [OS_W-1:0] os_cnt_reg;
  logic [BC_W-1:0] bit_cnt_reg;
  logic            os_tick_reg;
  logic            mid_tick_reg;
  logic            bit_tick_reg;
  logic            frame_done_reg;

  // The divisor is re-captured on the same tick that closes a bit, so any
  // change made mid-bit only applies from the next bit onwards.
  uart_frac_prescaler #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (bus.enable),
    .restart  (bus.restart),
    .reload   (os_wrap),
    .div_int  (bus.div_int),
    .div_frac (bus.div_frac),
    .tick     (raw_tick)
  );

  assign os_wrap    = raw_tick && (os_cnt_reg == OS_LAST);
  assign frame_wrap = os_wrap && (bit_cnt_reg == BIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_cnt_reg     <= '0;
      bit_cnt_reg    <= '0;
      os_tick_reg    <= 1'b0;
      mid_tick_reg   <= 1'b0;
      bit_tick_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      // raw_tick is already gated by enable and restart.
      os_tick_reg    <= raw_tick;
      mid_tick_reg   <= raw_tick && (os_cnt_reg == OS_PREMID);
      bit_tick_reg   <= os_wrap;
      frame_done_reg <= frame_wrap;
      if (bus.restart) begin
        os_cnt_reg  <= '0;
        bit_cnt_reg <= '0;
      end else if (raw_tick) begin
        os_cnt_reg <= os_wrap ? '0 : os_cnt_reg + 1'b1;
        if (os_wrap) begin
          bit_cnt_reg <= frame_wrap ? '0 : bit_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign bus.os_tick    = os_tick_reg;
  assign bus.mid_tick   = mid_tick_reg;
  assign bus.bit_tick   = bit_tick_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.os_cnt     = os_cnt_reg;
  assign bus.bit_cnt    = bit_cnt_reg;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: an event-level model (cycles since
// last tick, integer fraction accumulation) is compared against the DUT on
// every falling edge, plus hand-computed interval checks per scenario.
`timescale 1ns/1ps
module tb_uart_baud_gen;
  import uart_pkg::*;

  localparam int DIV_W      = 16;
  localparam int FRAC_W     = 4;
  localparam int OS_RATE    = 16;
  localparam int FRAME_BITS = 10;
  localparam int FRAC_ONE   = 1 << FRAC_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OS_RATE(OS_RATE),
                     .FRAME_BITS(FRAME_BITS)) bus ();

  uart_baud_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OS_RATE(OS_RATE),
                  .FRAME_BITS(FRAME_BITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- behavioural model ----------------
  int   m_div, m_frac, m_since, m_acc, m_carry, m_os, m_bits;
  logic e_os, e_mid, e_bit, e_frame;

  always @(posedge clk or negedge reset_n) begin : model
    int   div_n, frac_n, since_n, acc_n, carry_n, os_n, bits_n, per;
    logic os_x, mid_x, bit_x, frame_x;
    if (!reset_n) begin
      m_div <= 0; m_frac <= 0; m_since <= 0; m_acc <= 0; m_carry <= 0;
      m_os <= 0; m_bits <= 0;
      e_os <= 1'b0; e_mid <= 1'b0; e_bit <= 1'b0; e_frame <= 1'b0;
    end else begin
      div_n = m_div; frac_n = m_frac; since_n = m_since; acc_n = m_acc;
      carry_n = m_carry; os_n = m_os; bits_n = m_bits;
      os_x = 1'b0; mid_x = 1'b0; bit_x = 1'b0; frame_x = 1'b0;
      if (bus.restart) begin
        div_n = int'(bus.div_int); frac_n = int'(bus.div_frac);
        since_n = 0; acc_n = 0; carry_n = 0; os_n = 0; bits_n = 0;
      end else if (bus.enable) begin
        since_n = since_n + 1;
        per = ((div_n == 0) ? 1 : div_n) + carry_n;
        if (since_n >= per) begin
          since_n = 0;
          os_x = 1'b1;
          acc_n = acc_n + frac_n;
          carry_n = acc_n / FRAC_ONE;
          acc_n = acc_n % FRAC_ONE;
          os_n = (os_n + 1) % OS_RATE;
          mid_x = (os_n == OS_RATE / 2);
          bit_x = (os_n == 0);
          if (bit_x) begin
            frame_x = (bits_n == FRAME_BITS - 1);
            bits_n = (bits_n + 1) % FRAME_BITS;
            div_n = int'(bus.div_int);
            frac_n = int'(bus.div_frac);
          end
        end
      end
      m_div <= div_n; m_frac <= frac_n; m_since <= since_n; m_acc <= acc_n;
      m_carry <= carry_n; m_os <= os_n; m_bits <= bits_n;
      e_os <= os_x; e_mid <= mid_x; e_bit <= bit_x; e_frame <= frame_x;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic cyc();
    @(negedge clk);
    check("os_tick",    int'(bus.os_tick),    int'(e_os));
    check("mid_tick",   int'(bus.mid_tick),   int'(e_mid));
    check("bit_tick",   int'(bus.bit_tick),   int'(e_bit));
    check("frame_done", int'(bus.frame_done), int'(e_frame));
    check("os_cnt",     int'(bus.os_cnt),     m_os);
    check("bit_cnt",    int'(bus.bit_cnt),    m_bits);
  endtask

  // Cycles until the selected pulse (0 os,1 mid,2 bit,3 frame) is seen.
  task automatic wait_for(input int which, input int max, output int n);
    logic hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < max) begin
      cyc();
      n++;
      case (which)
        0: hit = bus.os_tick;
        1: hit = bus.mid_tick;
        2: hit = bus.bit_tick;
        default: hit = bus.frame_done;
      endcase
    end
    check("wait_hit", int'(hit), 1);
  endtask

  task automatic do_restart(input int div, input int frac);
    bus.div_int = DIV_W'(div);
    bus.div_frac = FRAC_W'(frac);
    bus.restart = 1'b1;
    cyc();
    bus.restart = 1'b0;
  endtask

  initial begin
    int n, sum, cnt;
    bus.enable = 1'b0;
    bus.restart = 1'b0;
    bus.div_int = '0;
    bus.div_frac = '0;

    // Reset state
    cyc(); cyc();
    check("rst_outputs", int'(bus.os_tick | bus.mid_tick | bus.bit_tick | bus.frame_done), 0);
    check("rst_os_cnt", int'(bus.os_cnt), 0);
    reset_n = 1'b1;
    cyc();

    // Integer divisor 4
    bus.enable = 1'b1;
    do_restart(4, 0);
    wait_for(0, 20, n);    check("int_first_os", n, 4);
    sum = n;
    wait_for(1, 100, n);   sum += n; check("int_mid", sum, 32);
    wait_for(2, 100, n);   sum += n; check("int_bit", sum, 64);
    wait_for(3, 1000, n);  sum += n; check("int_frame", sum, 640);
    check("int_frame_bit_tick", int'(bus.bit_tick), 1);
    check("int_frame_bit_cnt", int'(bus.bit_cnt), 0);
    wait_for(0, 20, n);    check("int_period", n, 4);

    // Fractional divisor 4 + 8/16
    do_restart(4, 8);
    wait_for(0, 20, n);    check("frac_iv1", n, 4);
    wait_for(0, 20, n);    check("frac_iv2", n, 4);
    sum = n;
    wait_for(0, 20, n);    check("frac_iv3", n, 5);
    sum += n;
    for (int i = 0; i < 14; i++) begin
      wait_for(0, 20, n);
      sum += n;
    end
    check("frac_sum16", sum, 72);

    // Enable gap of 7 cycles with pc = 2
    do_restart(4, 0);
    for (int i = 0; i < 3; i++) wait_for(0, 20, n);
    cyc(); cyc();
    bus.enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      cnt += int'(bus.os_tick) + int'(bus.mid_tick) + int'(bus.bit_tick) + int'(bus.frame_done);
    end
    check("gap_pulses", cnt, 0);
    check("gap_os_cnt", int'(bus.os_cnt), 3);
    check("gap_bit_cnt", int'(bus.bit_cnt), 0);
    bus.enable = 1'b1;
    wait_for(0, 20, n);    check("gap_resume", n, 2);
    check("gap_os_cnt_after", int'(bus.os_cnt), 4);

    // Restart on the prescaler terminal count
    cyc(); cyc(); cyc();
    do_restart(4, 0);
    check("coll_no_tick", int'(bus.os_tick), 0);
    check("coll_os_cnt", int'(bus.os_cnt), 0);
    check("coll_bit_cnt", int'(bus.bit_cnt), 0);
    wait_for(0, 20, n);    check("coll_first_os", n, 4);

    // Restart while enable is low
    wait_for(0, 20, n);
    check("dis_pre_os_cnt", int'(bus.os_cnt), 2);
    bus.enable = 1'b0;
    do_restart(4, 0);
    check("dis_os_cnt", int'(bus.os_cnt), 0);
    cyc(); cyc();
    bus.enable = 1'b1;
    wait_for(0, 20, n);    check("dis_first_os", n, 4);

    // Divisor change 4 -> 6 with os_cnt = 5
    do_restart(4, 0);
    for (int i = 0; i < 5; i++) wait_for(0, 20, n);
    check("chg_os_cnt", int'(bus.os_cnt), 5);
    bus.div_int = DIV_W'(6);
    wait_for(0, 20, n);    check("chg_old_period", n, 4);
    wait_for(2, 100, n);   check("chg_to_bit", n, 40);
    wait_for(0, 20, n);    check("chg_new_period", n, 6);

    // div_int = 0 behaves as 1
    do_restart(0, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      cnt += int'(bus.os_tick);
    end
    check("div0_continuous", cnt, 8);

    // Asynchronous reset at bit_cnt = 7
    do_restart(1, 0);
    n = 0;
    while (int'(bus.bit_cnt) != 7 && n < 500) begin
      cyc();
      n++;
    end
    check("rst_reach_bit7", int'(bus.bit_cnt), 7);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_flags", int'(bus.os_tick | bus.mid_tick | bus.bit_tick | bus.frame_done), 0);
    check("async_rst_os_cnt", int'(bus.os_cnt), 0);
    check("async_rst_bit_cnt", int'(bus.bit_cnt), 0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    check("post_rst_div0_tick", int'(bus.os_tick), 1);
    cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
